// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache pair, the arbiter and the single RAM port.
// The arbiter sits on the slave side; the caches and RAM model drive the master side.
interface mem_arbiter_if #(
    parameter int WORD_W = 32
) ();
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache: dcache priority,
// bounded by a starvation counter so a waiting icache always progresses.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [7:0] LIMIT      = 8'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nx;
    state_t     arb_sel;
    logic [7:0] starve_cnt;
    logic [7:0] starve_nx;
    logic       dreq;
    logic       access;
    logic       arb_en;

    assign dreq   = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RAM_ACCESS);

    // Choice made whenever the port is free or about to become free.
    always_comb begin
        arb_sel = IDLE;
        if (dreq && (!bus.iREN || starve_cnt < LIMIT))
            arb_sel = DGNT;
        else if (bus.iREN)
            arb_sel = IGNT;
    end

    always_comb begin
        state_nx = state;
        arb_en   = 1'b0;
        unique case (state)
            IDLE: arb_en = 1'b1;
            IGNT: begin
                if (!bus.iREN)
                    state_nx = IDLE;
                else if (access)
                    arb_en = 1'b1;
            end
            DGNT: begin
                if (!dreq)
                    state_nx = IDLE;
                else if (access)
                    arb_en = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (arb_en)
            state_nx = arb_sel;
    end

    // Counts dcache grants handed out while the icache is kept waiting.
    always_comb begin
        starve_nx = starve_cnt;
        if (!bus.iREN) begin
            starve_nx = 8'd0;
        end else if (arb_en) begin
            if (arb_sel == IGNT)
                starve_nx = 8'd0;
            else if (arb_sel == DGNT && starve_cnt < LIMIT)
                starve_nx = starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
        end
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        unique case (state)
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                if (access) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            DGNT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (access) begin
                    bus.dwait = 1'b0;
                    if (bus.dREN && !bus.dWEN)
                        bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus hand-written sequences for the
// starvation, withdrawal, error-hold and async-reset corners.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.WORD_W(32)) bus ();

    mem_arbiter #(
        .WORD_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic [1:0]  rs;
        logic        iwait;
        logic [31:0] iload;
        logic        dwait;
        logic [31:0] dload;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } vec_t;

    vec_t vt[12];

    function automatic logic [131:0] outs();
        return {bus.iwait, bus.iload, bus.dwait, bus.dload,
                bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore};
    endfunction

    task automatic chk(input string name,
                       input logic [131:0] act,
                       input logic [131:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic drive(input logic iren, input logic [31:0] iaddr,
                         input logic dren, input logic dwen,
                         input logic [31:0] daddr,
                         input logic [31:0] dstore,
                         input logic [31:0] ramload,
                         input logic [1:0] rs);
        bus.iREN     = iren;
        bus.iaddr    = iaddr;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.daddr    = daddr;
        bus.dstore   = dstore;
        bus.ramload  = ramload;
        bus.ramstate = rs;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [131:0] idle_o;
    string        exp_seq;
    byte          g;

    initial begin
        idle_o  = {1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        exp_seq = "DDDDIDDDDI";

        vt[0]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        2'd0,
                   1, 32'h0,    1, 32'h0,        0, 0, 32'h0,  32'h0};
        vt[1]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        32'h0,        2'd0,
                   1, 32'h0,    1, 32'h0,        0, 0, 32'h0,  32'h0};
        vt[2]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        32'h0,        2'd1,
                   1, 32'h0,    1, 32'h0,        1, 0, 32'h40, 32'h0};
        vt[3]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        32'h0,        2'd1,
                   1, 32'h0,    1, 32'h0,        1, 0, 32'h40, 32'h0};
        vt[4]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        32'h1234,     2'd2,
                   0, 32'h1234, 1, 32'h0,        1, 0, 32'h40, 32'h0};
        vt[5]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        2'd0,
                   1, 32'h0,    1, 32'h0,        0, 0, 32'h0,  32'h0};
        vt[6]  = '{0, 32'h0,  1, 1, 32'h80, 32'hDEADBEEF, 32'h0,        2'd0,
                   1, 32'h0,    1, 32'h0,        0, 0, 32'h0,  32'h0};
        vt[7]  = '{0, 32'h0,  1, 1, 32'h80, 32'hDEADBEEF, 32'h0,        2'd1,
                   1, 32'h0,    1, 32'h0,        0, 1, 32'h80, 32'hDEADBEEF};
        vt[8]  = '{0, 32'h0,  1, 1, 32'h80, 32'hDEADBEEF, 32'hAAAA5555, 2'd2,
                   1, 32'h0,    0, 32'h0,        0, 1, 32'h80, 32'hDEADBEEF};
        vt[9]  = '{0, 32'h0,  1, 0, 32'h84, 32'h0,        32'h11223344, 2'd2,
                   1, 32'h0,    0, 32'h11223344, 1, 0, 32'h84, 32'h0};
        vt[10] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        2'd0,
                   1, 32'h0,    1, 32'h0,        0, 0, 32'h0,  32'h0};
        vt[11] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        2'd0,
                   1, 32'h0,    1, 32'h0,        0, 0, 32'h0,  32'h0};

        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_outputs", outs(), idle_o);
        @(posedge CLK);
        @(posedge CLK);
        #3 nRST = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step();
            drive(vt[i].iren, vt[i].iaddr, vt[i].dren, vt[i].dwen,
                  vt[i].daddr, vt[i].dstore, vt[i].ramload, vt[i].rs);
            #1;
            chk($sformatf("vec%0d", i), outs(),
                {vt[i].iwait, vt[i].iload, vt[i].dwait, vt[i].dload,
                 vt[i].ren, vt[i].wen, vt[i].addr, vt[i].store});
        end

        // Both sides requesting, every access completes in one cycle.
        step();
        drive(1, 32'h10, 1, 0, 32'h20, 0, 32'h55, 2'd2);
        #1;
        chk("starve_idle", {bus.iwait, bus.dwait}, 132'(2'b11));
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            g = !bus.dwait ? "D" : (!bus.iwait ? "I" : "-");
            chk($sformatf("starve_grant%0d", i), 132'(g), 132'(exp_seq[i]));
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // dcache withdraws mid-BUSY; waiting icache follows.
        step();
        drive(1, 32'h100, 1, 0, 32'h30, 0, 0, 2'd1);
        step();
        #1;
        chk("wd_dgnt", {bus.ramREN, bus.dwait, bus.ramaddr},
            {1'b1, 1'b1, 32'h30});
        bus.dREN = 1'b0;
        #1;
        chk("wd_strobe_drop", {bus.ramREN, bus.ramWEN}, 132'(2'b00));
        step();
        #1;
        chk("wd_idle", {bus.ramREN, bus.iwait, bus.dwait},
            132'(3'b011));
        step();
        #1;
        chk("wd_ignt", {bus.ramREN, bus.iwait, bus.ramaddr},
            {1'b1, 1'b1, 32'h100});
        bus.iREN = 1'b0;
        bus.ramstate = 2'd0;
        step();
        step();

        // ERROR holds the icache grant until ACCESS arrives.
        step();
        drive(1, 32'h200, 0, 0, 0, 0, 0, 2'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk($sformatf("err_hold%0d", i),
                {bus.iwait, bus.ramREN, bus.ramaddr},
                {1'b1, 1'b1, 32'h200});
        end
        step();
        bus.ramstate = 2'd2;
        bus.ramload  = 32'hCAFEF00D;
        #1;
        chk("err_complete", {bus.iwait, bus.iload},
            {1'b0, 32'hCAFEF00D});
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Asynchronous reset in the middle of a dcache write.
        step();
        drive(0, 0, 0, 1, 32'h300, 32'h5, 0, 2'd1);
        step();
        #1;
        chk("rst_pre_wen", {bus.ramWEN, bus.ramaddr}, {1'b1, 32'h300});
        #1 nRST = 1'b0;
        #1;
        chk("rst_async", outs(), idle_o);
        #2 nRST = 1'b1;
        #1;
        chk("rst_idle_after", {bus.ramWEN, bus.dwait}, 132'(2'b01));
        step();
        #1;
        chk("rst_regrant", {bus.ramWEN, bus.ramstore}, {1'b1, 32'h5});
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
